fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage, placed in front of a multi-cycle (stalling) instruction memory.
- Owns the PC register and issues one fetch request at a time.
- Captures returned instructions into a one-entry fetch buffer and presents them to decode with a valid/stall handshake.
- Applies branch/jump redirects, halt, and error shutdown. Drops in-flight responses that a redirect has made stale.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, value driven on instr when no valid instruction is held

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall_in  in  1  decode cannot accept; hold the current instruction
redirect  in  1  taken branch/jump resolved downstream
redirect_pc  in  16  target PC for redirect
halt  in  1  HALT decoded; stop fetching
mem_addr  out  16  instruction memory address (= pc)
mem_en  out  1  fetch request strobe
mem_stall  in  1  memory busy; request in the same cycle is not accepted
mem_done  in  1  read data valid on mem_data
mem_data  in  16  read data
mem_err  in  1  memory error (unaligned access)
instr  out  16  fetched instruction (NOP_INSTR when instr_valid=0)
pc2  out  16  address of instr + 2
instr_valid  out  1  instr/pc2 valid for decode
halted  out  1  fetch stopped by halt
err  out  1  sticky fetch error

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=REQ, instr_valid=0, instr=NOP_INSTR, pc2=0, halted=0, err=0, halt_pend=0. mem_en=0 while reset is asserted.
- States:
  - REQ: may issue a request.
  - WAIT: one request is outstanding.
  - DRAIN: discard the outstanding response.
  - HALT: fetch stopped.
  - ERR: error shutdown.
- Slot free: slot_free = !instr_valid || !stall_in.
- Request and acceptance:
  - mem_en = (state==REQ) && slot_free && !redirect && !halt && (pc[0]==0).
  - mem_addr = pc at all times.
  - A request is accepted when mem_en=1 and mem_stall=0.
  - If mem_stall=1, stay in REQ and retry the next cycle with the same pc.
- Completion:
  - Accepted with mem_done in the same cycle (hit): capture at this edge and remain in REQ.
  - Accepted without mem_done: go to WAIT. mem_en=0 while in WAIT. On mem_done, capture and return to REQ.
- Capture (one edge): instr<=mem_data, pc2<=pc+2, pc<=pc+2, instr_valid<=1. Addition is 16-bit and wraps: 16'hFFFE -> 16'h0000.
- Consume: at any edge where instr_valid=1, stall_in=0 and there is no capture, instr_valid<=0. Capture and consume on the same edge leave instr_valid=1 with the new data.
- Throughput and latency: back-to-back hits with no stalls give one instruction per cycle. Request in cycle N gives instr_valid in cycle N+1.
- Redirect (highest priority after reset and err):
  - pc<=redirect_pc and instr_valid<=0 at this edge.
  - From REQ: stay in REQ. No request is issued this cycle.
  - From WAIT without mem_done: go to DRAIN.
  - From WAIT with mem_done in the same cycle: drop the data and go to REQ.
  - From DRAIN: update pc and remain in DRAIN.
  - From HALT or ERR: ignored.
- DRAIN: mem_en=0. On mem_done, discard the data and go to REQ, or to HALT if halt_pend=1.
- Halt (when redirect=0):
  - In REQ: go to HALT, instr_valid<=0.
  - In WAIT: set halt_pend and go to DRAIN.
  - HALT: mem_en=0, halted=1, instr_valid=0. Exit only by reset.
- Error: mem_err=1 with mem_done, or redirect_pc[0]=1 on a redirect, sends the block to ERR.
  - err=1 (sticky), mem_en=0, instr_valid=0.
  - Exit only by reset.
  - err takes precedence over redirect and halt.
- Reset mid-request: the response is lost. The memory is reset by the same rst.

Decomposition:
- Shared header fetch_ctrl_defs.vh holds:
  - state encodings (3-bit: REQ, WAIT, DRAIN, HALT, ERR),
  - the NOP_INSTR default,
  - the PC increment constant 16'd2.
- One sub-module: fetch_pc_reg, the 16-bit PC register with async active-low reset to RESET_PC, load-enable and +2 increment path. The FSM and fetch buffer stay in fetch_ctrl.

Test Plan:
- Hit stream: reset, then memory returns mem_done in the same cycle for addresses 0,2,4 with data 16'h1111/2222/3333 -> instr_valid from cycle 1, instr sequence 1111,2222,3333, pc2 2,4,6, one per cycle.
- Memory stall: mem_stall=1 for 3 cycles at pc=0 -> mem_en held 1 and mem_addr=0 for all 4 cycles; capture after the stall drops.
- Decode stall: instr_valid=1 with instr=16'hAAAA, stall_in=1 for 4 cycles -> instr/pc2 unchanged, mem_en=0; the next request issues the cycle stall_in falls.
- Redirect during WAIT: request at pc=4 outstanding, redirect=1 with redirect_pc=16'h0040, mem_done 2 cycles later with 16'hDEAD -> DEAD never presented; next mem_addr=0x0040 and instr_valid=0 until that fetch returns.
- Halt: halt=1 in REQ -> halted=1 next cycle, mem_en=0 forever; later redirect ignored; rst pulse low -> pc=RESET_PC and fetching resumes.
- Errors: redirect_pc=16'h0041 -> err=1 sticky. Separately, mem_err with mem_done -> err=1, instr_valid=0, mem_en=0 until reset.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl shared definitions: FSM state encoding,
// default NOP word and PC step used by the fetch controller.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_WAIT  = 3'd1,
      S_DRAIN = 3'd2,
      S_HALT  = 3'd3,
      S_ERR   = 3'd4
   } fetch_state_t;

   localparam logic [15:0] NOP_DEFAULT = 16'h0800;
   localparam logic [15:0] PC_INC      = 16'd2;

   // 16-bit wrapping increment to the next halfword-aligned instruction
   function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with async active-low reset,
// redirect load path and +2 increment path (load wins).
module fetch_pc_reg
   import fetch_ctrl_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [15:0] i_load_pc,
   input  logic        i_inc,
   output logic [15:0] o_pc,
   output logic [15:0] o_pc_inc
);

   logic [15:0] r_pc;

   // PC update: redirect target beats sequential advance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= i_load_pc;
      end else if (i_inc) begin
         r_pc <= pc_plus2(r_pc);
      end
   end

   assign o_pc     = r_pc;
   assign o_pc_inc = pc_plus2(r_pc);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer in front of a stalling instruction
// memory; one outstanding request, one-entry buffer to decode.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic [15:0] mem_addr,
   output logic        mem_en,
   input  logic        mem_stall,
   input  logic        mem_done,
   input  logic [15:0] mem_data,
   input  logic        mem_err,
   output logic [15:0] instr,
   output logic [15:0] pc2,
   output logic        instr_valid,
   output logic        halted,
   output logic        err
);

   fetch_state_t r_state;
   fetch_state_t w_next;

   logic [15:0] r_instr;
   logic [15:0] r_pc2;
   logic        r_valid;
   logic        r_hpend;

   logic [15:0] w_pc;
   logic [15:0] w_pc_inc;
   logic        w_slot_free;
   logic        w_en;
   logic        w_acc;
   logic        w_live;
   logic        w_resp;
   logic        w_err;
   logic        w_cap;
   logic        w_load;
   logic        w_clr;
   logic        w_hpend_set;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_load_pc (redirect_pc),
      .i_inc     (w_cap),
      .o_pc      (w_pc),
      .o_pc_inc  (w_pc_inc)
   );

   assign w_slot_free = !r_valid || !stall_in;
   assign w_live = (r_state == S_REQ) ||
                   (r_state == S_WAIT) ||
                   (r_state == S_DRAIN);

   assign w_en = rst && (r_state == S_REQ) &&
                 w_slot_free && !redirect &&
                 !halt && !w_pc[0];
   assign w_acc = w_en && !mem_stall;

   // a response only counts against a request we actually own
   assign w_resp = mem_done &&
                   (w_acc || (r_state == S_WAIT) ||
                    (r_state == S_DRAIN));

   assign w_err = w_live &&
                  ((w_resp && mem_err) ||
                   (redirect && redirect_pc[0]));

   // next-state, capture and redirect decisions (priority ordered)
   always_comb begin
      w_next      = r_state;
      w_cap       = 1'b0;
      w_load      = 1'b0;
      w_clr       = 1'b0;
      w_hpend_set = 1'b0;
      if (!w_live) begin
         w_next = r_state;
      end else if (w_err) begin
         w_next = S_ERR;
         w_clr  = 1'b1;
      end else if (redirect) begin
         w_load = 1'b1;
         w_clr  = 1'b1;
         if (r_state == S_WAIT) begin
            w_next = mem_done ? S_REQ : S_DRAIN;
         end else if (r_state == S_DRAIN && mem_done) begin
            w_next = r_hpend ? S_HALT : S_REQ;
         end
      end else if (halt) begin
         w_clr = 1'b1;
         if (r_state == S_REQ || mem_done) begin
            w_next = S_HALT;
         end else begin
            w_hpend_set = 1'b1;
            w_next      = S_DRAIN;
         end
      end else begin
         unique case (r_state)
            S_REQ: begin
               if (w_acc && mem_done) begin
                  w_cap = 1'b1;
               end else if (w_acc) begin
                  w_next = S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_done) begin
                  w_cap  = 1'b1;
                  w_next = S_REQ;
               end
            end
            S_DRAIN: begin
               if (mem_done) begin
                  w_next = r_hpend ? S_HALT : S_REQ;
               end
            end
            default: w_next = r_state;
         endcase
      end
   end

   // state register and pending-halt flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_REQ;
         r_hpend <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_hpend_set) begin
            r_hpend <= 1'b1;
         end
      end
   end

   // one-entry fetch buffer toward decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
         r_pc2   <= 16'h0000;
      end else if (w_clr ||
                   w_next == S_HALT ||
                   w_next == S_ERR) begin
         r_valid <= 1'b0;
      end else if (w_cap) begin
         r_valid <= 1'b1;
         r_instr <= mem_data;
         r_pc2   <= w_pc_inc;
      end else if (r_valid && !stall_in) begin
         r_valid <= 1'b0;
      end
   end

   assign mem_addr    = w_pc;
   assign mem_en      = w_en;
   assign instr       = r_valid ? r_instr : NOP_INSTR;
   assign pc2         = r_pc2;
   assign instr_valid = r_valid;
   assign halted      = (r_state == S_HALT);
   assign err         = (r_state == S_ERR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed pins plus randomized traffic against a
// transaction-level model of the fetch controller.
module tb_fetch_ctrl;

   localparam logic [15:0] RPC = 16'h0000;
   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic        mem_stall = 1'b0;
   logic        mem_done = 1'b0;
   logic [15:0] mem_data = 16'h0000;
   logic        mem_err = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_en;
   logic [15:0] instr;
   logic [15:0] pc2;
   logic        instr_valid;
   logic        halted;
   logic        err;

   fetch_ctrl #(
      .RESET_PC  (RPC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_in    (stall_in),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .mem_addr    (mem_addr),
      .mem_en      (mem_en),
      .mem_stall   (mem_stall),
      .mem_done    (mem_done),
      .mem_data    (mem_data),
      .mem_err     (mem_err),
      .instr       (instr),
      .pc2         (pc2),
      .instr_valid (instr_valid),
      .halted      (halted),
      .err         (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm,
                       input logic act,
                       input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_pc = RPC;
   logic [15:0] m_instr = 16'h0000;
   logic [15:0] m_pc2 = 16'h0000;
   bit m_v = 0, m_out = 0, m_stale = 0;
   bit m_stop = 0, m_fail = 0, m_hpend = 0;
   bit mb_acc, mb_got;

   function automatic bit m_en();
      return rst && !m_out && !m_stop && !m_fail &&
             (!m_v || !stall_in) && !redirect &&
             !halt && !m_pc[0];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc = RPC; m_instr = 16'h0000; m_pc2 = 16'h0000;
         m_v = 0; m_out = 0; m_stale = 0;
         m_stop = 0; m_fail = 0; m_hpend = 0;
      end else if (!m_stop && !m_fail) begin
         mb_acc = m_en() && !mem_stall;
         mb_got = mem_done && (mb_acc || m_out);
         if ((mb_got && mem_err) ||
             (redirect && redirect_pc[0])) begin
            m_fail = 1; m_v = 0; m_out = 0;
         end else if (redirect) begin
            m_pc = redirect_pc;
            m_v = 0;
            if (m_out && !mb_got) begin
               m_stale = 1;
            end else begin
               if (m_out && m_hpend) m_stop = 1;
               m_out = 0; m_stale = 0;
            end
         end else if (halt) begin
            m_v = 0;
            if (m_out && !mb_got) begin
               m_hpend = 1; m_stale = 1;
            end else begin
               m_stop = 1; m_out = 0;
            end
         end else if (mb_got && !m_stale) begin
            m_instr = mem_data;
            m_pc = m_pc + 16'd2;
            m_pc2 = m_pc;
            m_v = 1;
            m_out = 0;
         end else begin
            if (mb_got) begin
               m_out = 0; m_stale = 0;
               if (m_hpend) m_stop = 1;
            end
            if (mb_acc) m_out = 1;
            if (m_v && !stall_in) m_v = 0;
            if (m_stop) m_v = 0;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk1("mem_en", mem_en, m_en());
      chk("mem_addr", mem_addr, m_pc);
      chk1("instr_valid", instr_valid, m_v);
      chk("instr", instr, m_v ? m_instr : NOP);
      chk("pc2", pc2, m_pc2);
      chk1("halted", halted, m_stop);
      chk1("err", err, m_fail);
   end

   // ---------------- memory responder ----------------
   int unsigned p_stall = 0, p_hit = 100, p_err = 0;
   int unsigned lat_max = 0;
   bit dir_data = 1;
   bit pend = 0;
   int unsigned lat = 0;

   always @(negedge clk) begin
      if (!rst) begin
         pend = 0;
      end else if (mem_done) begin
         pend = 0;
      end else if (mem_en && !mem_stall) begin
         pend = 1;
         lat = $urandom_range(lat_max, 0);
      end
   end

   task automatic step(input bit r, input bit s,
                       input bit rd, input logic [15:0] rpc,
                       input bit h);
      @(posedge clk);
      #1;
      rst = r; stall_in = s; redirect = rd;
      redirect_pc = rpc; halt = h;
      mem_stall = ($urandom_range(99, 0) < p_stall);
      #1;
      if (pend) begin
         mem_done = rst && (lat == 0);
         if (lat != 0) lat--;
      end else begin
         mem_done = mem_en && !mem_stall &&
                    ($urandom_range(99, 0) < p_hit);
      end
      mem_err = mem_done && ($urandom_range(99, 0) < p_err);
      mem_data = dir_data ?
         16'(32'h1111 * (32'(mem_addr >> 1) + 32'd1)) :
         16'($urandom);
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   bit r_b, s_b, rd_b, h_b;
   logic [15:0] rv;

   initial begin
      #2 rst = 0;
      step(0, 0, 0, 16'h0, 0);
      chk1("rst_en", mem_en, 1'b0);
      chk("rst_instr", instr, 16'h0800);
      chk("rst_pc2", pc2, 16'h0000);
      chk1("rst_valid", instr_valid, 1'b0);

      // hit stream 0,2,4
      step(1, 0, 0, 16'h0, 0);
      chk1("hit_en0", mem_en, 1'b1);
      chk("hit_addr0", mem_addr, 16'h0000);
      step(1, 0, 0, 16'h0, 0);
      chk("hit_i1", instr, 16'h1111);
      chk("hit_p1", pc2, 16'h0002);
      step(1, 0, 0, 16'h0, 0);
      chk("hit_i2", instr, 16'h2222);
      chk("hit_p2", pc2, 16'h0004);
      step(1, 0, 0, 16'h0, 0);
      chk("hit_i3", instr, 16'h3333);
      chk("hit_p3", pc2, 16'h0006);

      // decode stall holds 4444 from address 6
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0, 16'h0, 0);
         chk("dstall_instr", instr, 16'h4444);
         chk("dstall_pc2", pc2, 16'h0008);
         chk1("dstall_en", mem_en, 1'b0);
      end
      step(1, 0, 0, 16'h0, 0);
      chk1("dstall_resume", mem_en, 1'b1);
      chk("dstall_addr", mem_addr, 16'h0008);

      // memory stall on address 10
      p_stall = 100;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 16'h0, 0);
         chk1("mstall_en", mem_en, 1'b1);
         chk("mstall_addr", mem_addr, 16'h000A);
      end
      p_stall = 0;
      step(1, 0, 0, 16'h0, 0);

      // redirect while a miss is outstanding
      p_hit = 0; lat_max = 1; dir_data = 0;
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 1, 16'h0040, 0);
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      chk("redir_addr", mem_addr, 16'h0040);
      chk1("redir_valid", instr_valid, 1'b0);

      // halt, ignored redirect, reset recovery
      p_hit = 100; lat_max = 0;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 1);
      step(1, 0, 0, 16'h0, 0);
      chk1("halt_flag", halted, 1'b1);
      chk1("halt_en", mem_en, 1'b0);
      step(1, 0, 1, 16'h0080, 0);
      step(1, 0, 0, 16'h0, 0);
      chk1("halt_sticky", halted, 1'b1);
      step(0, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      chk1("halt_rst_en", mem_en, 1'b1);
      chk("halt_rst_addr", mem_addr, RPC);

      // odd redirect target
      step(1, 0, 1, 16'h0041, 0);
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      chk1("oddpc_err", err, 1'b1);
      chk1("oddpc_en", mem_en, 1'b0);
      step(0, 0, 0, 16'h0, 0);

      // memory error on a hit
      p_err = 100;
      step(1, 0, 0, 16'h0, 0);
      step(1, 0, 0, 16'h0, 0);
      chk1("merr_err", err, 1'b1);
      chk1("merr_valid", instr_valid, 1'b0);
      p_err = 0;
      step(0, 0, 0, 16'h0, 0);

      // randomized traffic
      p_stall = 25; p_hit = 40; p_err = 2; lat_max = 3;
      for (int c = 0; c < 3000; c++) begin
         r_b = 1;
         if ((m_stop || m_fail) && $urandom_range(7, 0) == 0)
            r_b = 0;
         if ($urandom_range(299, 0) == 0) r_b = 0;
         s_b = ($urandom_range(99, 0) < 30);
         rd_b = ($urandom_range(99, 0) < 6);
         h_b = ($urandom_range(99, 0) < 2);
         rv = 16'($urandom);
         rv[0] = ($urandom_range(49, 0) == 0);
         step(r_b, s_b, rd_b, rv, h_b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
